// File: rtl/id_ex_registro_riesgos_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | id_ex_registro_riesgos_if : ID->EX bus with stall/flush controls   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface id_ex_registro_riesgos_if #(
  parameter int NB_DATA = 32,
  parameter int RNBITS  = 5,
  parameter int NB_CTRL = 8,
  parameter int NB_CNT  = 16
);
  logic               i_enable;
  logic               i_flush;
  logic               i_clr_cnt;
  logic [NB_DATA-1:0] i_pc4;
  logic [NB_DATA-1:0] i_dato_a;
  logic [NB_DATA-1:0] i_dato_b;
  logic [NB_DATA-1:0] i_inmediato;
  logic [RNBITS-1:0]  i_rs;
  logic [RNBITS-1:0]  i_rt;
  logic [RNBITS-1:0]  i_rd;
  logic               i_usa_rs;
  logic               i_usa_rt;
  logic [NB_CTRL-1:0] i_ctrl;

  logic [NB_DATA-1:0] o_pc4;
  logic [NB_DATA-1:0] o_dato_a;
  logic [NB_DATA-1:0] o_dato_b;
  logic [NB_DATA-1:0] o_inmediato;
  logic [RNBITS-1:0]  o_rs;
  logic [RNBITS-1:0]  o_rt;
  logic [RNBITS-1:0]  o_rd;
  logic [NB_CTRL-1:0] o_ctrl;
  logic               o_valido;
  logic               o_stall;
  logic [NB_CNT-1:0]  o_cnt_burbujas;

  modport master (
    output i_enable, i_flush, i_clr_cnt, i_pc4, i_dato_a, i_dato_b, i_inmediato,
           i_rs, i_rt, i_rd, i_usa_rs, i_usa_rt, i_ctrl,
    input  o_pc4, o_dato_a, o_dato_b, o_inmediato, o_rs, o_rt, o_rd, o_ctrl,
           o_valido, o_stall, o_cnt_burbujas
  );

  modport slave (
    input  i_enable, i_flush, i_clr_cnt, i_pc4, i_dato_a, i_dato_b, i_inmediato,
           i_rs, i_rt, i_rd, i_usa_rs, i_usa_rt, i_ctrl,
    output o_pc4, o_dato_a, o_dato_b, o_inmediato, o_rs, o_rt, o_rd, o_ctrl,
           o_valido, o_stall, o_cnt_burbujas
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_registro_riesgos.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | id_ex_registro_riesgos : ID/EX register with load-use bubble       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module id_ex_registro_riesgos #(
  parameter int NB_DATA = 32,
  parameter int RNBITS  = 5,
  parameter int NB_CTRL = 8,
  parameter int NB_CNT  = 16
) (
  input  wire logic i_clk,
  input  wire logic i_reset,
  id_ex_registro_riesgos_if.slave bus
);

  localparam logic [NB_CNT-1:0] c_cnt_max = '1;

  logic [NB_DATA-1:0] r_pc4;
  logic [NB_DATA-1:0] r_dato_a;
  logic [NB_DATA-1:0] r_dato_b;
  logic [NB_DATA-1:0] r_inmediato;
  logic [RNBITS-1:0]  r_rs;
  logic [RNBITS-1:0]  r_rt;
  logic [RNBITS-1:0]  r_rd;
  logic [NB_CTRL-1:0] r_ctrl;
  logic               r_valido;
  logic [NB_CNT-1:0]  r_cnt;

  logic w_haz;
  logic w_bubble;

  // Load in EX whose destination is read by the instruction in ID; $0 is never a dependency
  assign w_haz = r_valido & r_ctrl[1] & (r_rt != '0) &
                 ((bus.i_usa_rs & (bus.i_rs == r_rt)) | (bus.i_usa_rt & (bus.i_rt == r_rt)));
  assign w_bubble = bus.i_flush | w_haz;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pc4       <= '0;
      r_dato_a    <= '0;
      r_dato_b    <= '0;
      r_inmediato <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_ctrl      <= '0;
      r_valido    <= 1'b0;
    end else if (bus.i_enable) begin
      if (w_bubble) begin
        r_pc4       <= '0;
        r_dato_a    <= '0;
        r_dato_b    <= '0;
        r_inmediato <= '0;
        r_rs        <= '0;
        r_rt        <= '0;
        r_rd        <= '0;
        r_ctrl      <= '0;
        r_valido    <= 1'b0;
      end else begin
        r_pc4       <= bus.i_pc4;
        r_dato_a    <= bus.i_dato_a;
        r_dato_b    <= bus.i_dato_b;
        r_inmediato <= bus.i_inmediato;
        r_rs        <= bus.i_rs;
        r_rt        <= bus.i_rt;
        r_rd        <= bus.i_rd;
        r_ctrl      <= bus.i_ctrl;
        r_valido    <= 1'b1;
      end
    end
  end

  // Only hazard bubbles are counted; a clear in the same cycle takes precedence
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (bus.i_enable) begin
      if (bus.i_clr_cnt) begin
        r_cnt <= '0;
      end else if (w_haz && !bus.i_flush && (r_cnt != c_cnt_max)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.o_pc4          = r_pc4;
  assign bus.o_dato_a       = r_dato_a;
  assign bus.o_dato_b       = r_dato_b;
  assign bus.o_inmediato    = r_inmediato;
  assign bus.o_rs           = r_rs;
  assign bus.o_rt           = r_rt;
  assign bus.o_rd           = r_rd;
  assign bus.o_ctrl         = r_ctrl;
  assign bus.o_valido       = r_valido;
  assign bus.o_stall        = w_haz & bus.i_enable & ~bus.i_flush;
  assign bus.o_cnt_burbujas = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_registro_riesgos.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_id_ex_registro_riesgos : self-checking bench for ID/EX register |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_id_ex_registro_riesgos;

  localparam int NB_DATA = 32;
  localparam int RNBITS  = 5;
  localparam int NB_CTRL = 8;
  localparam int NB_CNT  = 8;   // narrow counter keeps saturation reachable quickly

  localparam logic [NB_CTRL-1:0] c_lw  = 8'h0B;
  localparam logic [NB_CTRL-1:0] c_add = 8'h81;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  bit   cmp_en;

  id_ex_registro_riesgos_if #(
    .NB_DATA(NB_DATA), .RNBITS(RNBITS), .NB_CTRL(NB_CTRL), .NB_CNT(NB_CNT)
  ) bus ();

  id_ex_registro_riesgos #(
    .NB_DATA(NB_DATA), .RNBITS(RNBITS), .NB_CTRL(NB_CTRL), .NB_CNT(NB_CNT)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected contents of the EX stage, kept as one record
  typedef struct {
    logic [NB_DATA-1:0] pc4, a, b, imm;
    logic [RNBITS-1:0]  rs, rt, rd;
    logic [NB_CTRL-1:0] ctrl;
    logic               valido;
  } ex_t;

  ex_t m_ex;
  int  m_cnt;
  localparam int c_cnt_sat = (1 << NB_CNT) - 1;

  function automatic logic exp_haz();
    logic lee;
    lee = (bus.i_usa_rs && bus.i_rs == m_ex.rt) || (bus.i_usa_rt && bus.i_rt == m_ex.rt);
    return m_ex.valido && m_ex.ctrl[1] && (m_ex.rt != 0) && lee;
  endfunction

  function automatic ex_t empty_ex();
    ex_t e;
    e = '{pc4: '0, a: '0, b: '0, imm: '0, rs: '0, rt: '0, rd: '0, ctrl: '0, valido: 1'b0};
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex  <= empty_ex();
      m_cnt <= 0;
    end else if (bus.i_enable) begin
      if (bus.i_clr_cnt) m_cnt <= 0;
      else if (!bus.i_flush && exp_haz()) m_cnt <= (m_cnt < c_cnt_sat) ? m_cnt + 1 : m_cnt;
      if (bus.i_flush || exp_haz()) m_ex <= empty_ex();
      else m_ex <= '{pc4: bus.i_pc4, a: bus.i_dato_a, b: bus.i_dato_b, imm: bus.i_inmediato,
                     rs: bus.i_rs, rt: bus.i_rt, rd: bus.i_rd, ctrl: bus.i_ctrl, valido: 1'b1};
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("pc4",    64'(bus.o_pc4),          64'(m_ex.pc4));
      check("dato_a", 64'(bus.o_dato_a),       64'(m_ex.a));
      check("dato_b", 64'(bus.o_dato_b),       64'(m_ex.b));
      check("inm",    64'(bus.o_inmediato),    64'(m_ex.imm));
      check("rs",     64'(bus.o_rs),           64'(m_ex.rs));
      check("rt",     64'(bus.o_rt),           64'(m_ex.rt));
      check("rd",     64'(bus.o_rd),           64'(m_ex.rd));
      check("ctrl",   64'(bus.o_ctrl),         64'(m_ex.ctrl));
      check("valido", 64'(bus.o_valido),       64'(m_ex.valido));
      check("cnt",    64'(bus.o_cnt_burbujas), 64'(m_cnt));
      check("stall",  64'(bus.o_stall),        64'(rst_n && exp_haz() && bus.i_enable && !bus.i_flush));
    end
  end

  task automatic set_id(input logic [NB_DATA-1:0] pc4, input logic [NB_DATA-1:0] a,
                        input logic [RNBITS-1:0] rs, input logic [RNBITS-1:0] rt,
                        input logic [RNBITS-1:0] rd, input logic urs, input logic urt,
                        input logic [NB_CTRL-1:0] ctrl);
    bus.i_pc4       = pc4;
    bus.i_dato_a    = a;
    bus.i_dato_b    = a ^ 32'hFFFF_0000;
    bus.i_inmediato = pc4 + 32'h10;
    bus.i_rs        = rs;
    bus.i_rt        = rt;
    bus.i_rd        = rd;
    bus.i_usa_rs    = urs;
    bus.i_usa_rt    = urt;
    bus.i_ctrl      = ctrl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cmp_en  = 1'b0;
    rst_n   = 1'b0;
    bus.i_enable  = 1'b1;
    bus.i_flush   = 1'b0;
    bus.i_clr_cnt = 1'b0;
    set_id(32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, '0);
    #2;
    cmp_en = 1'b1;

    // Reset holds everything at zero regardless of inputs
    for (int i = 0; i < 3; i++) begin
      set_id($urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 8'hFF);
      tick();
    end
    check("rst_valido", 64'(bus.o_valido), 64'd0);
    check("rst_ctrl",   64'(bus.o_ctrl), 64'd0);
    check("rst_cnt",    64'(bus.o_cnt_burbujas), 64'd0);
    check("rst_stall",  64'(bus.o_stall), 64'd0);
    rst_n = 1'b1;

    // First capture after reset
    set_id(32'h100, 32'h1234, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, c_add);
    tick();
    check("cap_rs",     64'(bus.o_rs), 64'd3);
    check("cap_dato_a", 64'(bus.o_dato_a), 64'h1234);
    check("cap_valido", 64'(bus.o_valido), 64'd1);

    // Load-use: lw $8 in EX, add reading $8 in ID
    set_id(32'h104, 32'h0, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0, c_lw);
    tick();
    set_id(32'h108, 32'h55, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, c_add);
    #1;
    check("lu_stall", 64'(bus.o_stall), 64'd1);
    tick();
    check("lu_ctrl",   64'(bus.o_ctrl), 64'd0);
    check("lu_valido", 64'(bus.o_valido), 64'd0);
    check("lu_cnt",    64'(bus.o_cnt_burbujas), 64'd1);
    check("lu_stall2", 64'(bus.o_stall), 64'd0);
    tick();
    check("lu_rs",   64'(bus.o_rs), 64'd8);
    check("lu_ctrl2", 64'(bus.o_ctrl), 64'(c_add));

    // No false stall on $0, nor on an Rt the instruction does not read
    set_id(32'h10C, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, c_lw);
    tick();
    set_id(32'h110, 32'h7, 5'd0, 5'd2, 5'd3, 1'b1, 1'b1, c_add);
    #1;
    check("z0_stall", 64'(bus.o_stall), 64'd0);
    tick();
    check("z0_valido", 64'(bus.o_valido), 64'd1);
    set_id(32'h114, 32'h0, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0, c_lw);
    tick();
    set_id(32'h118, 32'h9, 5'd1, 5'd8, 5'd4, 1'b1, 1'b0, c_add);
    #1;
    check("rt_stall", 64'(bus.o_stall), 64'd0);
    tick();
    check("rt_rt",  64'(bus.o_rt), 64'd8);
    check("rt_cnt", 64'(bus.o_cnt_burbujas), 64'd1);

    // Flush wins over hazard
    set_id(32'h11C, 32'h0, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0, c_lw);
    tick();
    set_id(32'h120, 32'h9, 5'd8, 5'd2, 5'd4, 1'b1, 1'b1, c_add);
    bus.i_flush = 1'b1;
    #1;
    check("fl_stall", 64'(bus.o_stall), 64'd0);
    tick();
    bus.i_flush = 1'b0;
    check("fl_valido", 64'(bus.o_valido), 64'd0);
    check("fl_cnt",    64'(bus.o_cnt_burbujas), 64'd1);

    // Hold with hazard present
    set_id(32'h124, 32'h0, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0, c_lw);
    tick();
    bus.i_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_id(32'h200 + 32'(i * 4), 32'(i), 5'd8, 5'd8, 5'(i), 1'b1, 1'b1, c_add);
      #1;
      check("hold_stall", 64'(bus.o_stall), 64'd0);
      tick();
    end
    check("hold_pc4",  64'(bus.o_pc4), 64'h124);
    check("hold_ctrl", 64'(bus.o_ctrl), 64'(c_lw));
    check("hold_cnt",  64'(bus.o_cnt_burbujas), 64'd1);
    bus.i_enable = 1'b1;
    #1;
    check("resume_stall", 64'(bus.o_stall), 64'd1);
    tick();
    check("resume_cnt", 64'(bus.o_cnt_burbujas), 64'd2);

    // Counter clear, saturation, clear beating a simultaneous bubble
    bus.i_clr_cnt = 1'b1;
    set_id(32'h300, 32'h1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, c_add);
    tick();
    bus.i_clr_cnt = 1'b0;
    check("clr_cnt", 64'(bus.o_cnt_burbujas), 64'd0);
    for (int i = 0; i < c_cnt_sat + 1; i++) begin
      set_id(32'h400, 32'h0, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, c_lw);
      tick();
      set_id(32'h404, 32'h2, 5'd8, 5'd8, 5'd6, 1'b1, 1'b1, c_add);
      tick();
      if (i == c_cnt_sat - 1) check("sat_reach", 64'(bus.o_cnt_burbujas), 64'hFF);
    end
    check("sat_hold", 64'(bus.o_cnt_burbujas), 64'hFF);
    set_id(32'h408, 32'h0, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, c_lw);
    tick();
    set_id(32'h40C, 32'h2, 5'd8, 5'd8, 5'd6, 1'b1, 1'b1, c_add);
    bus.i_clr_cnt = 1'b1;
    tick();
    bus.i_clr_cnt = 1'b0;
    check("clr_bub_cnt",    64'(bus.o_cnt_burbujas), 64'd0);
    check("clr_bub_valido", 64'(bus.o_valido), 64'd0);

    // Reset asserted in the middle of a stall cycle
    set_id(32'h500, 32'h0, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, c_lw);
    tick();
    set_id(32'h504, 32'h3, 5'd8, 5'd1, 5'd7, 1'b1, 1'b0, c_add);
    #1;
    check("mid_stall_pre", 64'(bus.o_stall), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_stall",  64'(bus.o_stall), 64'd0);
    check("mid_valido", 64'(bus.o_valido), 64'd0);
    check("mid_pc4",    64'(bus.o_pc4), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rs",     64'(bus.o_rs), 64'd8);
    check("post_valido", 64'(bus.o_valido), 64'd1);
    tick();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
